// File: rtl/uart_tx_scheduler.sv
// Packet scheduler sharing one byte-wide UART transmitter between the
// SDRAM pixel stream and door/motion status words.
//
// Every transfer goes out as a packet: SYNC_BYTE, type, payload, csum.
// Type 8'h01 carries CHUNK_LEN pixel bytes and 8'h02 carries one 16-bit
// status word, high byte first. csum is the XOR of the type byte and all
// payload bytes. Arbitration happens only between packets, and ties are
// broken round-robin.
//
// Ports:
//   CLOCK_50, RESET_N       clock; asynchronous active-low reset
//   enable                  allow new grants (in-flight packet completes)
//   frame_req               level request from the pixel path
//   pix_data/valid/ready    pixel byte stream (pass-through in PAYLOAD)
//   stat_req, stat_word     status capture pulse and word
//   stat_pend, stat_drop    status waiting / sticky overwrite flag
//   tx_data/valid/ready     byte stream to the UART serializer
//   sched_state             FSM state for debug display
//   chunks_sent             completed frame packets (wrapping)
module uart_tx_scheduler #(
    parameter int unsigned CHUNK_LEN = 64,
    parameter logic [7:0]  SYNC_BYTE = 8'hA5
) (
    input  logic        CLOCK_50,
    input  logic        RESET_N,
    input  logic        enable,
    input  logic        frame_req,
    input  logic [7:0]  pix_data,
    input  logic        pix_valid,
    output logic        pix_ready,
    input  logic        stat_req,
    input  logic [15:0] stat_word,
    output logic        stat_pend,
    output logic        stat_drop,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic [2:0]  sched_state,
    output logic [15:0] chunks_sent
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        SYNC    = 3'd1,
        TYPE    = 3'd2,
        PAYLOAD = 3'd3,
        CSUM    = 3'd4
    } state_t;

    localparam logic [7:0] TYPE_FRAME = 8'h01;
    localparam logic [7:0] TYPE_STAT  = 8'h02;
    localparam logic [7:0] LAST_IDX   = 8'(CHUNK_LEN - 1);

    state_t      state;
    logic        cur_stat;
    logic        last_grant;
    logic        tx_valid_q;
    logic [7:0]  tx_data_q;
    logic [7:0]  byte_cnt;
    logic [7:0]  csum;

    logic [15:0] hold_word;
    logic [15:0] def_word;
    logic        def_valid;

    logic        frame_pay;
    logic        xfer;
    logic        pay_last;
    logic        grant;
    logic        grant_stat;
    logic        frozen;
    logic        stat_done;

    // Frame payload bytes bypass the output registers so the pixel
    // stream flows at full rate with the serializer's backpressure.
    always_comb begin
        frame_pay = (state == PAYLOAD) && !cur_stat;
        tx_valid  = frame_pay ? pix_valid : tx_valid_q;
        tx_data   = frame_pay ? pix_data  : tx_data_q;
        pix_ready = frame_pay && tx_ready;
    end

    assign xfer        = tx_valid && tx_ready;
    assign sched_state = state;

    // last_grant: 1 = status was granted most recently.
    always_comb begin
        grant      = enable && (frame_req || stat_pend);
        grant_stat = stat_pend && (!frame_req || !last_grant);
        pay_last   = cur_stat ? (byte_cnt == 8'd1)
                              : (byte_cnt == LAST_IDX);
        frozen     = cur_stat && ((state == PAYLOAD) || (state == CSUM));
        stat_done  = cur_stat && (state == CSUM) && xfer;
    end

    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            state       <= IDLE;
            cur_stat    <= 1'b0;
            last_grant  <= 1'b0;
            tx_valid_q  <= 1'b0;
            tx_data_q   <= 8'h00;
            byte_cnt    <= 8'h00;
            csum        <= 8'h00;
            chunks_sent <= 16'h0000;
        end else begin
            unique case (state)
                IDLE: begin
                    csum     <= 8'h00;
                    byte_cnt <= 8'h00;
                    if (grant) begin
                        state      <= SYNC;
                        cur_stat   <= grant_stat;
                        last_grant <= grant_stat;
                        tx_valid_q <= 1'b1;
                        tx_data_q  <= SYNC_BYTE;
                    end
                end
                SYNC: begin
                    if (xfer) begin
                        state     <= TYPE;
                        tx_data_q <= cur_stat ? TYPE_STAT : TYPE_FRAME;
                    end
                end
                TYPE: begin
                    if (xfer) begin
                        state    <= PAYLOAD;
                        csum     <= csum ^ tx_data;
                        byte_cnt <= 8'h00;
                        if (cur_stat) begin
                            // A word arriving on this very edge still
                            // replaces the one about to be sent.
                            tx_data_q <= stat_req ? stat_word[15:8]
                                                  : hold_word[15:8];
                        end else begin
                            tx_valid_q <= 1'b0;
                        end
                    end
                end
                PAYLOAD: begin
                    if (xfer) begin
                        csum     <= csum ^ tx_data;
                        byte_cnt <= byte_cnt + 8'd1;
                        if (pay_last) begin
                            state      <= CSUM;
                            tx_valid_q <= 1'b1;
                            tx_data_q  <= csum ^ tx_data;
                        end else if (cur_stat) begin
                            tx_data_q <= hold_word[7:0];
                        end
                    end
                end
                CSUM: begin
                    if (xfer) begin
                        state      <= IDLE;
                        tx_valid_q <= 1'b0;
                        tx_data_q  <= 8'h00;
                        if (!cur_stat) begin
                            chunks_sent <= chunks_sent + 16'd1;
                        end
                    end
                end
                default: begin
                    state      <= IDLE;
                    tx_valid_q <= 1'b0;
                end
            endcase
        end
    end

    // Status holding register. While a status packet is past TYPE the
    // register is frozen; a new word waits in def_word and moves in when
    // the csum goes out, keeping stat_pend set for another packet.
    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            hold_word <= 16'h0000;
            def_word  <= 16'h0000;
            def_valid <= 1'b0;
            stat_pend <= 1'b0;
            stat_drop <= 1'b0;
        end else begin
            if (stat_req && stat_pend) begin
                stat_drop <= 1'b1;
            end
            if (stat_req && frozen && !stat_done) begin
                def_valid <= 1'b1;
                def_word  <= stat_word;
            end else if (stat_req) begin
                hold_word <= stat_word;
                stat_pend <= 1'b1;
                def_valid <= 1'b0;
            end else if (stat_done) begin
                if (def_valid) begin
                    hold_word <= def_word;
                    def_valid <= 1'b0;
                end else begin
                    stat_pend <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Self-checking bench for uart_tx_scheduler: directed packet table,
// hand-written corner sequences and a randomized packet-level model.
module tb_uart_tx_scheduler;

    localparam int CL = 4;

    logic        clk;
    logic        rst_n;
    logic        enable;
    logic        frame_req;
    logic [7:0]  pix_data;
    logic        pix_valid;
    logic        pix_ready;
    logic        stat_req;
    logic [15:0] stat_word;
    logic        stat_pend;
    logic        stat_drop;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic [2:0]  sched_state;
    logic [15:0] chunks_sent;

    uart_tx_scheduler #(
        .CHUNK_LEN(CL),
        .SYNC_BYTE(8'hA5)
    ) dut (
        .CLOCK_50   (clk),
        .RESET_N    (rst_n),
        .enable     (enable),
        .frame_req  (frame_req),
        .pix_data   (pix_data),
        .pix_valid  (pix_valid),
        .pix_ready  (pix_ready),
        .stat_req   (stat_req),
        .stat_word  (stat_word),
        .stat_pend  (stat_pend),
        .stat_drop  (stat_drop),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .sched_state(sched_state),
        .chunks_sent(chunks_sent)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_cmp = 0;
    int          n_err = 0;
    int          cyc = 0;
    int          pix_idx = 0;
    int          exp_chunks = 0;
    logic [7:0]  pix_mem [1024];
    logic [7:0]  got_b [$];
    int          got_t [$];
    logic [15:0] sreq_w [$];
    int          sreq_t [$];
    logic [7:0]  exp_q [$];
    logic        chk_stab = 1'b0;
    logic        prev_stall = 1'b0;
    logic [7:0]  prev_data = 8'h00;
    logic        last_cons = 1'b0;

    typedef struct {
        logic        is_stat;
        logic [15:0] word;
        logic [7:0]  pix [4];
        logic [7:0]  exp [7];
        int          len;
    } vec_t;

    vec_t vecs [6];

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name, input int act, input int exp);
        n_cmp++;
        n_err++;
        $display("FAIL %s: got %0d, required %0d", name, act, exp);
    endtask

    // One clock: settle, sample away from the edge, take the edge.
    task automatic step();
        logic cons;
        pix_data = pix_mem[pix_idx % 1024];
        #1;
        if (chk_stab && prev_stall) begin
            check("hold_valid", tx_valid, 1);
            check("hold_data", tx_data, prev_data);
        end
        if (tx_valid && tx_ready) begin
            got_b.push_back(tx_data);
            got_t.push_back(cyc);
        end
        if (stat_req) begin
            sreq_w.push_back(stat_word);
            sreq_t.push_back(cyc);
        end
        prev_stall = tx_valid && !tx_ready;
        prev_data  = tx_data;
        cons       = pix_valid && pix_ready;
        last_cons  = cons;
        @(posedge clk);
        cyc++;
        if (cons) pix_idx++;
        @(negedge clk);
    endtask

    task automatic pulse_stat(input logic [15:0] w);
        stat_word = w;
        stat_req  = 1'b1;
        step();
        stat_req  = 1'b0;
    endtask

    task automatic run_until(input int n, input int budget, input int drop_at);
        int k;
        k = 0;
        while (got_b.size() < n && k < budget) begin
            if (got_b.size() >= drop_at) frame_req = 1'b0;
            step();
            k++;
        end
        if (got_b.size() < n) fail_now("timeout_bytes", got_b.size(), n);
    endtask

    function automatic void clear_q();
        got_b.delete();
        got_t.delete();
        exp_q.delete();
    endfunction

    function automatic void add_stat(input logic [15:0] w);
        exp_q.push_back(8'hA5);
        exp_q.push_back(8'h02);
        exp_q.push_back(w[15:8]);
        exp_q.push_back(w[7:0]);
        exp_q.push_back(8'h02 ^ w[15:8] ^ w[7:0]);
    endfunction

    function automatic void add_frame(input int start);
        logic [7:0] c;
        c = 8'h01;
        exp_q.push_back(8'hA5);
        exp_q.push_back(8'h01);
        for (int k = 0; k < CL; k++) begin
            exp_q.push_back(pix_mem[(start + k) % 1024]);
            c = c ^ pix_mem[(start + k) % 1024];
        end
        exp_q.push_back(c);
    endfunction

    task automatic cmp_stream(input string name);
        check({name, "_len"}, got_b.size(), exp_q.size());
        for (int i = 0; i < exp_q.size(); i++) begin
            if (i < got_b.size()) check(name, got_b[i], exp_q[i]);
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        check({tag, "_tx_valid"}, tx_valid, 0);
        check({tag, "_tx_data"}, tx_data, 0);
        check({tag, "_pix_ready"}, pix_ready, 0);
        check({tag, "_stat_pend"}, stat_pend, 0);
        check({tag, "_stat_drop"}, stat_drop, 0);
        check({tag, "_state"}, sched_state, 0);
        check({tag, "_chunks"}, chunks_sent, 0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int e0;
        int k;
        int stall;
        logic started;

        for (int i = 0; i < 1024; i++) pix_mem[i] = 8'($urandom);

        vecs[0] = '{1'b1, 16'h1234, '{0, 0, 0, 0},
                    '{8'hA5, 8'h02, 8'h12, 8'h34, 8'h24, 0, 0}, 5};
        vecs[1] = '{1'b0, 16'h0000, '{8'h01, 8'h02, 8'h03, 8'h04},
                    '{8'hA5, 8'h01, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05}, 7};
        vecs[2] = '{1'b1, 16'hABCD, '{0, 0, 0, 0},
                    '{8'hA5, 8'h02, 8'hAB, 8'hCD, 8'h64, 0, 0}, 5};
        vecs[3] = '{1'b0, 16'h0000, '{8'h10, 8'h20, 8'h30, 8'h40},
                    '{8'hA5, 8'h01, 8'h10, 8'h20, 8'h30, 8'h40, 8'h41}, 7};
        vecs[4] = '{1'b1, 16'h0000, '{0, 0, 0, 0},
                    '{8'hA5, 8'h02, 8'h00, 8'h00, 8'h02, 0, 0}, 5};
        vecs[5] = '{1'b0, 16'h0000, '{8'hFF, 8'hFF, 8'hFF, 8'hFF},
                    '{8'hA5, 8'h01, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h01}, 7};

        rst_n     = 1'b0;
        enable    = 1'b0;
        frame_req = 1'b0;
        pix_valid = 1'b0;
        pix_data  = 8'h00;
        stat_req  = 1'b0;
        stat_word = 16'h0000;
        tx_ready  = 1'b1;
        @(negedge clk);
        repeat (3) step();
        chk_reset_vals("reset");
        rst_n = 1'b1;
        step();

        // Ties straight after reset: status first, then frame, twice.
        for (int t = 0; t < 2; t++) begin
            clear_q();
            enable = 1'b0;
            pulse_stat(t == 0 ? 16'h5A5A : 16'h6B6B);
            frame_req = 1'b1;
            pix_valid = 1'b1;
            step();
            step();
            add_stat(t == 0 ? 16'h5A5A : 16'h6B6B);
            add_frame(pix_idx);
            enable = 1'b1;
            run_until(5 + CL + 3, 100, 6);
            cmp_stream(t == 0 ? "tie1" : "tie2");
            exp_chunks++;
            check("tie_chunks", chunks_sent, exp_chunks);
            pix_valid = 1'b0;
            step();
        end

        // Directed packet table.
        foreach (vecs[v]) begin
            clear_q();
            for (int i = 0; i < vecs[v].len; i++) exp_q.push_back(vecs[v].exp[i]);
            enable = 1'b1;
            tx_ready = 1'b1;
            e0 = cyc;
            if (vecs[v].is_stat) begin
                pulse_stat(vecs[v].word);
            end else begin
                for (int i = 0; i < CL; i++)
                    pix_mem[(pix_idx + i) % 1024] = vecs[v].pix[i];
                frame_req = 1'b1;
                pix_valid = 1'b1;
            end
            run_until(vecs[v].len, 50, 1);
            cmp_stream("vec_bytes");
            if (got_b.size() == vecs[v].len) begin
                check("vec_latency", got_t[0] - e0, vecs[v].is_stat ? 2 : 1);
                check("vec_b2b", got_t[vecs[v].len - 1] - got_t[0],
                      vecs[v].len - 1);
            end
            check("vec_idle_after", sched_state, 0);
            if (vecs[v].is_stat) begin
                check("vec_pend_clear", stat_pend, 0);
            end else begin
                exp_chunks++;
                check("vec_chunks", chunks_sent, exp_chunks);
            end
            pix_valid = 1'b0;
        end

        // Two captures before grant: only the newer word goes out.
        clear_q();
        enable = 1'b0;
        pulse_stat(16'h1111);
        pulse_stat(16'h2222);
        check("drop_flag", stat_drop, 1);
        check("drop_pend", stat_pend, 1);
        add_stat(16'h2222);
        enable = 1'b1;
        run_until(5, 50, 1);
        cmp_stream("drop_pkt");
        check("drop_pend_clear", stat_pend, 0);
        check("drop_sticky", stat_drop, 1);

        // Pixel stall of 10 cycles mid-payload under random backpressure.
        clear_q();
        add_frame(pix_idx);
        frame_req = 1'b1;
        pix_valid = 1'b1;
        stall = 0;
        started = 1'b0;
        k = 0;
        while (got_b.size() < CL + 3 && k < 300) begin
            if (got_b.size() >= 1) frame_req = 1'b0;
            tx_ready = 1'($urandom_range(0, 1));
            if (got_b.size() == 4 && !started) begin
                started = 1'b1;
                stall = 10;
            end
            pix_valid = (stall == 0);
            if (stall > 0) stall--;
            step();
            k++;
        end
        if (got_b.size() < CL + 3) fail_now("stall_timeout", got_b.size(), CL + 3);
        cmp_stream("stall_pkt");
        exp_chunks++;
        check("stall_chunks", chunks_sent, exp_chunks);
        tx_ready = 1'b1;

        // Reset mid-payload, then hold off grants with enable low.
        clear_q();
        enable = 1'b1;
        frame_req = 1'b1;
        pix_valid = 1'b1;
        k = 0;
        while (sched_state != 3'd3 && k < 20) begin
            step();
            k++;
        end
        step();
        enable = 1'b0;
        rst_n = 1'b0;
        #1;
        chk_reset_vals("rst_mid");
        step();
        rst_n = 1'b1;
        exp_chunks = 0;
        pulse_stat(16'h0BAD);
        clear_q();
        repeat (6) step();
        check("nogrant_bytes", got_b.size(), 0);
        check("nogrant_state", sched_state, 0);
        check("nogrant_pend", stat_pend, 1);
        add_stat(16'h0BAD);
        add_frame(pix_idx);
        enable = 1'b1;
        e0 = cyc;
        run_until(5 + CL + 3, 100, 6);
        if (got_b.size() > 0) check("rst_latency", got_t[0] - e0, 1);
        cmp_stream("rst_pkts");
        exp_chunks++;
        check("rst_chunks", chunks_sent, exp_chunks);

        // Randomized traffic checked at packet level.
        begin
            int p0;
            int i;
            int nfr;
            int fidx;
            int prev_tt;
            int tt;
            logic [15:0] ew;
            logic [15:0] last_sent;
            logic found;
            logic fresh;
            logic have_sent;
            logic [7:0] c;

            got_b.delete();
            got_t.delete();
            sreq_w.delete();
            sreq_t.delete();
            p0 = pix_idx;
            prev_stall = 1'b0;
            chk_stab = 1'b1;
            for (int n = 0; n < 3000; n++) begin
                if ($urandom_range(0, 15) == 0) frame_req = ~frame_req;
                enable = ($urandom_range(0, 9) != 0);
                tx_ready = ($urandom_range(0, 3) != 0);
                if (!(pix_valid && !last_cons)) pix_valid = 1'($urandom_range(0, 1));
                stat_req = ($urandom_range(0, 29) == 0);
                stat_word = 16'($urandom);
                step();
            end
            stat_req = 1'b0;
            frame_req = 1'b0;
            enable = 1'b1;
            tx_ready = 1'b1;
            pix_valid = 1'b1;
            repeat (40) step();
            chk_stab = 1'b0;

            i = 0;
            nfr = 0;
            fidx = p0;
            prev_tt = -1;
            have_sent = 1'b0;
            last_sent = 16'h0000;
            while (i < got_b.size()) begin
                check("rnd_sync", got_b[i], 8'hA5);
                if (i + 1 >= got_b.size()) begin
                    fail_now("rnd_truncated", got_b.size(), i + 2);
                    break;
                end
                if (got_b[i + 1] == 8'h02) begin
                    if (i + 4 >= got_b.size()) begin
                        fail_now("rnd_truncated", got_b.size(), i + 5);
                        break;
                    end
                    tt = got_t[i + 1];
                    ew = 16'h0000;
                    found = 1'b0;
                    fresh = 1'b0;
                    for (int j = 0; j < sreq_t.size(); j++) begin
                        if (sreq_t[j] <= tt) begin
                            ew = sreq_w[j];
                            found = 1'b1;
                            if (sreq_t[j] > prev_tt) fresh = 1'b1;
                        end
                    end
                    check("rnd_stat_has_req", found && fresh, 1);
                    check("rnd_stat_word", {got_b[i + 2], got_b[i + 3]}, ew);
                    check("rnd_stat_csum", got_b[i + 4], 8'h02 ^ ew[15:8] ^ ew[7:0]);
                    prev_tt = tt;
                    last_sent = ew;
                    have_sent = 1'b1;
                    i += 5;
                end else if (got_b[i + 1] == 8'h01) begin
                    if (i + CL + 2 >= got_b.size()) begin
                        fail_now("rnd_truncated", got_b.size(), i + CL + 3);
                        break;
                    end
                    c = 8'h01;
                    for (int q = 0; q < CL; q++) begin
                        check("rnd_pix", got_b[i + 2 + q], pix_mem[(fidx + q) % 1024]);
                        c = c ^ pix_mem[(fidx + q) % 1024];
                    end
                    check("rnd_frame_csum", got_b[i + 2 + CL], c);
                    fidx += CL;
                    nfr++;
                    i += CL + 3;
                end else begin
                    fail_now("rnd_type", got_b[i + 1], 1);
                    break;
                end
            end
            check("rnd_pix_count", pix_idx - p0, nfr * CL);
            exp_chunks += nfr;
            check("rnd_chunks", chunks_sent, 16'(exp_chunks));
            check("rnd_pend_drained", stat_pend, 0);
            check("rnd_idle", sched_state, 0);
            if (sreq_w.size() > 0) begin
                check("rnd_any_stat", have_sent, 1);
                check("rnd_last_word", last_sent, sreq_w[sreq_w.size() - 1]);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/uart_tx_scheduler.md
# uart_tx_scheduler

Packet-level scheduler that shares the single byte-wide UART transmitter between two requesters.
- Frame requester: pixel bytes read out of SDRAM by the camera capture path.
- Status requester: door/motion event words.

It wraps each transfer in a framed packet (sync, type, payload, XOR checksum) and arbitrates only at packet boundaries. It sits between the SDRAM readout stream and the UART serializer. It replaces direct wiring of the pixel stream into the sender.

## Interface
Parameters:
- CHUNK_LEN, 64: payload bytes per frame packet; legal range 1..255.
- SYNC_BYTE, 8'hA5: first byte of every packet.

Ports:
- CLOCK_50  in  1  system clock; all logic on rising edge.
- RESET_N  in  1  asynchronous, active-low reset.
- enable  in  1  when low, no new packet is granted; an in-flight packet still completes.
- frame_req  in  1  level; high while frame data is available to send.
- pix_data  in  8  frame payload byte.
- pix_valid  in  1  pix_data valid.
- pix_ready  out  1  pix_data consumed this cycle when pix_valid && pix_ready.
- stat_req  in  1  single-cycle pulse; latches stat_word.
- stat_word  in  16  status payload, captured on stat_req.
- stat_pend  out  1  a latched status word is waiting to be sent.
- stat_drop  out  1  sticky; set when stat_req arrives while stat_pend is already high.
- tx_data  out  8  byte to UART serializer.
- tx_valid  out  1  tx_data valid.
- tx_ready  in  1  serializer accepts; a byte transfers when tx_valid && tx_ready.
- sched_state  out  3  current FSM state encoding, for debug/HEX display.
- chunks_sent  out  16  count of completed frame packets; wraps 0xFFFF -> 0.

## Operation
- Packet format: SYNC_BYTE, type, payload, csum.
  - Type is 8'h01 for a frame packet (CHUNK_LEN bytes) and 8'h02 for a status packet (stat_word[15:8], then stat_word[7:0]).
  - csum is the XOR of the type byte and all payload bytes; SYNC_BYTE is excluded.
- FSM states and encodings: IDLE=0, SYNC=1, TYPE=2, PAYLOAD=3, CSUM=4.
  - SYNC, TYPE and CSUM each advance on a transfer.
  - PAYLOAD advances after its last payload byte transfers.
  - CSUM returns to IDLE.
- Arbitration in IDLE:
  - A request counts as pending if it is frame_req, or stat_pend.
  - A grant is made only when enable=1 and at least one request is pending.
  - If both are pending, grant the requester not granted last (round-robin bit last_grant).
  - last_grant resets to "frame", so status wins the first tie.
- Status latch:
  - On stat_req, stat_word is copied into the holding register and stat_pend is set.
  - stat_pend clears on the transfer of the status CSUM byte.
  - If stat_req arrives while stat_pend=1, the holding word is overwritten and stat_drop is set.
  - If a status packet is already past TYPE, the holding register is frozen. A stat_req arriving then is held and applied at the status CSUM transfer; stat_pend stays set.
  - If stat_req coincides with the status CSUM transfer, the new word is latched and stat_pend stays 1.
- Frame PAYLOAD:
  - tx_valid=pix_valid, tx_data=pix_data, pix_ready=tx_ready (combinational pass-through).
  - A byte counter counts transfers up to CHUNK_LEN.
  - pix_valid low stalls the packet indefinitely; no timeout.
- pix_ready is 0 in every state other than frame PAYLOAD.
- frame_req deasserting mid-packet does not abort; the packet completes with CHUNK_LEN bytes.
- chunks_sent increments on the transfer of a frame CSUM byte.
- Checksum register clears in IDLE and XORs each type/payload byte as it transfers.

## Timing
- Reset values: tx_valid=0, tx_data=0, pix_ready=0, stat_pend=0, stat_drop=0, sched_state=0, chunks_sent=0, last_grant=frame.
- Reset mid-packet returns to IDLE immediately; the partial packet is abandoned and no CSUM is sent.
- Grant latency: a request seen in IDLE at edge N puts tx_valid=1 with SYNC_BYTE in cycle N+1.
- Back-to-back bytes: with tx_ready held high, one byte transfers per cycle.
  - Status packet occupies 5 cycles from SYNC through CSUM.
  - Frame packet occupies CHUNK_LEN+3 cycles.
  - One IDLE cycle separates consecutive packets.
- tx_data and tx_valid are held stable while tx_valid=1 and tx_ready=0 (frame PAYLOAD follows pix_data, whose source must also hold).

## Test plan
- Status only, stat_word=16'h1234, tx_ready=1 -> bytes A5 02 12 34 24; stat_pend clears on the 24 transfer.
- Frame only, CHUNK_LEN=4, pixels 01 02 03 04 -> bytes A5 01 01 02 03 04 05; chunks_sent=1.
- Both pending in IDLE after reset -> status packet first, then frame packet; a second tie -> status then frame again, proving alternation.
- pix_valid dropped for 10 cycles mid-payload and tx_ready toggled randomly -> byte order and csum unchanged; no duplicated or lost bytes.
- Two stat_req pulses (1111, then 2222) before grant -> a single packet carrying 22 22; stat_drop=1.
- RESET_N pulsed low during frame PAYLOAD, and enable=0 with requests pending -> outputs return to reset values; no grant until enable=1; then a full packet starts with A5.
